// File: rtl/urv_dmem_responder.sv
// urv_dmem_responder: data-memory responder for the uRV core.
// Serves a local byte-enabled RAM with single-cycle throughput. All other
// addresses go to an external req/ack bus with one access outstanding and
// a timeout that returns 32'hDEAD_BEEF and raises a sticky error flag.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  IDLE     | ready; RAM accesses complete here, EXT accesses leave
//  EXT_BUSY | ext_req_o high, waiting for ack or timeout; not ready
//  EXT_DONE | EXT completion pulse; ready, may accept the next request
module urv_dmem_responder #(
    parameter int g_ram_words      = 4096,
    parameter int g_timeout_cycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic [31:0] ext_addr_o,
    output logic [31:0] ext_data_o,
    output logic [3:0]  ext_sel_o,
    output logic        ext_we_o,
    output logic        ext_req_o,
    input  logic        ext_ack_i,
    input  logic [31:0] ext_data_i,
    output logic        err_o,
    output logic [31:0] err_addr_o,
    input  logic        err_clr_i
);

    localparam int          c_aw        = $clog2(g_ram_words);
    localparam logic [32:0] c_ram_bytes = 33'(4 * g_ram_words);
    localparam logic [15:0] c_tmo_last  = 16'(g_timeout_cycles - 1);
    localparam logic [31:0] c_tmo_data  = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXT_BUSY = 2'd1,
        EXT_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        load_done_q, load_done_d;
    logic        store_done_q, store_done_d;
    logic [31:0] data_l_q, data_l_d;
    logic [31:0] ext_addr_q, ext_addr_d;
    logic [31:0] ext_data_q, ext_data_d;
    logic [3:0]  ext_sel_q, ext_sel_d;
    logic        ext_we_q, ext_we_d;
    logic        err_q, err_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic [31:0]     mem [g_ram_words];
    logic [c_aw-1:0] ram_idx;
    logic [31:0]     ram_rdata;
    logic            ram_hit;
    logic            ram_we;
    logic            accept;

    assign ram_idx   = dm_addr_i[c_aw+1:2];
    assign ram_rdata = mem[ram_idx];
    assign ram_hit   = ({1'b0, dm_addr_i} < c_ram_bytes);

    // Ready depends on state alone so the core sees no comb path from its strobes.
    assign dm_ready_o = (state_q != EXT_BUSY);
    assign accept     = (dm_load_i | dm_store_i) & dm_ready_o;

    // Next-state, completion and error logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        load_done_d  = 1'b0;
        store_done_d = 1'b0;
        data_l_d     = data_l_q;
        ext_addr_d   = ext_addr_q;
        ext_data_d   = ext_data_q;
        ext_sel_d    = ext_sel_q;
        ext_we_d     = ext_we_q;
        err_d        = err_q;
        err_addr_d   = err_addr_q;
        ram_we       = 1'b0;

        if (err_clr_i) begin
            err_d      = 1'b0;
            err_addr_d = 32'h0;
        end

        case (state_q)
            IDLE, EXT_DONE: begin
                state_d = IDLE;
                if (accept) begin
                    if (ram_hit) begin
                        // Store takes priority when both strobes are high.
                        ram_we       = dm_store_i;
                        store_done_d = dm_store_i;
                        load_done_d  = ~dm_store_i;
                        if (!dm_store_i) begin
                            data_l_d = ram_rdata;
                        end
                    end else begin
                        ext_addr_d = dm_addr_i;
                        ext_data_d = dm_data_s_i;
                        ext_sel_d  = dm_data_select_i;
                        ext_we_d   = dm_store_i;
                        cnt_d      = 16'h0;
                        state_d    = EXT_BUSY;
                    end
                end
            end
            EXT_BUSY: begin
                if (ext_ack_i) begin
                    // Ack beats a same-cycle timeout.
                    state_d      = EXT_DONE;
                    cnt_d        = 16'h0;
                    store_done_d = ext_we_q;
                    load_done_d  = ~ext_we_q;
                    if (!ext_we_q) begin
                        data_l_d = ext_data_i;
                    end
                end else if (cnt_q == c_tmo_last) begin
                    state_d      = EXT_DONE;
                    cnt_d        = 16'h0;
                    store_done_d = ext_we_q;
                    load_done_d  = ~ext_we_q;
                    if (!ext_we_q) begin
                        data_l_d = c_tmo_data;
                    end
                    // Setting beats a same-cycle clear; a clear also restarts "first address".
                    err_d = 1'b1;
                    if (!err_q || err_clr_i) begin
                        err_addr_d = ext_addr_q;
                    end
                end else begin
                    cnt_d = cnt_q + 16'h1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= 16'h0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            data_l_q     <= 32'h0;
            ext_addr_q   <= 32'h0;
            ext_data_q   <= 32'h0;
            ext_sel_q    <= 4'h0;
            ext_we_q     <= 1'b0;
            err_q        <= 1'b0;
            err_addr_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            load_done_q  <= load_done_d;
            store_done_q <= store_done_d;
            data_l_q     <= data_l_d;
            ext_addr_q   <= ext_addr_d;
            ext_data_q   <= ext_data_d;
            ext_sel_q    <= ext_sel_d;
            ext_we_q     <= ext_we_d;
            err_q        <= err_d;
            err_addr_q   <= err_addr_d;
        end
    end

    // Local RAM byte-lane writes; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we && dm_data_select_i[b]) begin
                mem[ram_idx][b*8 +: 8] <= dm_data_s_i[b*8 +: 8];
            end
        end
    end

    assign dm_load_done_o  = load_done_q;
    assign dm_store_done_o = store_done_q;
    assign dm_data_l_o     = data_l_q;
    assign ext_addr_o      = ext_addr_q;
    assign ext_data_o      = ext_data_q;
    assign ext_sel_o       = ext_sel_q;
    assign ext_we_o        = ext_we_q;
    assign ext_req_o       = (state_q == EXT_BUSY);
    assign err_o           = err_q;
    assign err_addr_o      = err_addr_q;

endmodule

// File: tb/tb_urv_dmem_responder.sv
// Directed bench for urv_dmem_responder with an 8-cycle external timeout.
module tb_urv_dmem_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_s_i;
    logic [3:0]  dm_data_select_i;
    logic        dm_store_i;
    logic        dm_load_i;
    logic        dm_ready_o;
    logic [31:0] dm_data_l_o;
    logic        dm_load_done_o;
    logic        dm_store_done_o;
    logic [31:0] ext_addr_o;
    logic [31:0] ext_data_o;
    logic [3:0]  ext_sel_o;
    logic        ext_we_o;
    logic        ext_req_o;
    logic        ext_ack_i;
    logic [31:0] ext_data_i;
    logic        err_o;
    logic [31:0] err_addr_o;
    logic        err_clr_i;

    int checks = 0;
    int errors = 0;

    urv_dmem_responder #(
        .g_ram_words      (4096),
        .g_timeout_cycles (8)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .dm_addr_i        (dm_addr_i),
        .dm_data_s_i      (dm_data_s_i),
        .dm_data_select_i (dm_data_select_i),
        .dm_store_i       (dm_store_i),
        .dm_load_i        (dm_load_i),
        .dm_ready_o       (dm_ready_o),
        .dm_data_l_o      (dm_data_l_o),
        .dm_load_done_o   (dm_load_done_o),
        .dm_store_done_o  (dm_store_done_o),
        .ext_addr_o       (ext_addr_o),
        .ext_data_o       (ext_data_o),
        .ext_sel_o        (ext_sel_o),
        .ext_we_o         (ext_we_o),
        .ext_req_o        (ext_req_o),
        .ext_ack_i        (ext_ack_i),
        .ext_data_i       (ext_data_i),
        .err_o            (err_o),
        .err_addr_o       (err_addr_o),
        .err_clr_i        (err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i = 1'b1; dm_addr_i = 32'h0; dm_data_s_i = 32'h0; dm_data_select_i = 4'h0;
        dm_store_i = 1'b0; dm_load_i = 1'b0; ext_ack_i = 1'b0; ext_data_i = 32'h0;
        err_clr_i = 1'b0;
        tick(); tick();

        // Reset values
        chk("rst_ready", 32'(dm_ready_o), 32'd1);
        chk("rst_ld_done", 32'(dm_load_done_o), 32'd0);
        chk("rst_st_done", 32'(dm_store_done_o), 32'd0);
        chk("rst_data_l", dm_data_l_o, 32'h0);
        chk("rst_req", 32'(ext_req_o), 32'd0);
        chk("rst_we", 32'(ext_we_o), 32'd0);
        chk("rst_ext_addr", ext_addr_o, 32'h0);
        chk("rst_ext_data", ext_data_o, 32'h0);
        chk("rst_ext_sel", 32'(ext_sel_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_err_addr", err_addr_o, 32'h0);
        rst_i = 1'b0;
        tick();

        // RAM round trip with partial byte write
        dm_store_i = 1'b1; dm_addr_i = 32'h10; dm_data_s_i = 32'h1234_5678; dm_data_select_i = 4'b1111;
        tick();
        chk("st1_done", 32'(dm_store_done_o), 32'd1);
        chk("st1_no_ld", 32'(dm_load_done_o), 32'd0);
        dm_data_s_i = 32'hAAAA_BBBB; dm_data_select_i = 4'b0010;
        tick();
        chk("st2_done", 32'(dm_store_done_o), 32'd1);
        dm_store_i = 1'b0; dm_load_i = 1'b1;
        tick();
        chk("rt_ld_done", 32'(dm_load_done_o), 32'd1);
        chk("rt_ld_data", dm_data_l_o, 32'h1234_BB78);
        chk("rt_st_pulse", 32'(dm_store_done_o), 32'd0);
        dm_load_i = 1'b0;
        tick();
        chk("rt_ld_pulse", 32'(dm_load_done_o), 32'd0);

        // Zero byte-enable store completes but changes nothing
        dm_store_i = 1'b1; dm_data_s_i = 32'hFFFF_FFFF; dm_data_select_i = 4'b0000;
        tick();
        chk("sel0_done", 32'(dm_store_done_o), 32'd1);
        dm_store_i = 1'b0; dm_load_i = 1'b1;
        tick();
        chk("sel0_data", dm_data_l_o, 32'h1234_BB78);
        dm_load_i = 1'b0;

        // RAM back-to-back: fill three words, then read them on consecutive cycles
        dm_store_i = 1'b1; dm_data_select_i = 4'b1111;
        dm_addr_i = 32'h0; dm_data_s_i = 32'h1111_1111;
        tick();
        dm_addr_i = 32'h4; dm_data_s_i = 32'h2222_2222;
        tick();
        dm_addr_i = 32'h8; dm_data_s_i = 32'h3333_3333;
        tick();
        chk("fill_done", 32'(dm_store_done_o), 32'd1);
        dm_store_i = 1'b0; dm_load_i = 1'b1; dm_addr_i = 32'h0;
        tick();
        chk("b2b0_done", 32'(dm_load_done_o), 32'd1);
        chk("b2b0_data", dm_data_l_o, 32'h1111_1111);
        chk("b2b0_ready", 32'(dm_ready_o), 32'd1);
        dm_addr_i = 32'h4;
        tick();
        chk("b2b1_done", 32'(dm_load_done_o), 32'd1);
        chk("b2b1_data", dm_data_l_o, 32'h2222_2222);
        chk("b2b1_ready", 32'(dm_ready_o), 32'd1);
        dm_addr_i = 32'h8;
        tick();
        chk("b2b2_done", 32'(dm_load_done_o), 32'd1);
        chk("b2b2_data", dm_data_l_o, 32'h3333_3333);
        chk("b2b2_ready", 32'(dm_ready_o), 32'd1);
        dm_load_i = 1'b0;
        tick();
        chk("b2b_end", 32'(dm_load_done_o), 32'd0);

        // EXT read, acked on the third request cycle
        dm_load_i = 1'b1; dm_addr_i = 32'h0010_0000; dm_data_select_i = 4'b1111;
        tick();
        dm_load_i = 1'b0;
        chk("ext_req1", 32'(ext_req_o), 32'd1);
        chk("ext_we", 32'(ext_we_o), 32'd0);
        chk("ext_addr", ext_addr_o, 32'h0010_0000);
        chk("ext_sel", 32'(ext_sel_o), 32'hF);
        chk("ext_rdy1", 32'(dm_ready_o), 32'd0);
        tick();
        chk("ext_req2", 32'(ext_req_o), 32'd1);
        chk("ext_rdy2", 32'(dm_ready_o), 32'd0);
        chk("ext_nodone2", 32'(dm_load_done_o), 32'd0);
        tick();
        chk("ext_req3", 32'(ext_req_o), 32'd1);
        chk("ext_rdy3", 32'(dm_ready_o), 32'd0);
        ext_ack_i = 1'b1; ext_data_i = 32'hCAFE_0001;
        tick();
        ext_ack_i = 1'b0; ext_data_i = 32'h0;
        chk("ext_req_off", 32'(ext_req_o), 32'd0);
        chk("ext_ld_done", 32'(dm_load_done_o), 32'd1);
        chk("ext_ld_data", dm_data_l_o, 32'hCAFE_0001);
        chk("ext_done_rdy", 32'(dm_ready_o), 32'd1);
        // RAM load accepted in the EXT completion cycle
        dm_load_i = 1'b1; dm_addr_i = 32'h10;
        tick();
        chk("after_ext_done", 32'(dm_load_done_o), 32'd1);
        chk("after_ext_data", dm_data_l_o, 32'h1234_BB78);
        dm_load_i = 1'b0;
        tick();
        chk("after_ext_end", 32'(dm_load_done_o), 32'd0);

        // EXT store timeout
        dm_store_i = 1'b1; dm_addr_i = 32'h8000_0004; dm_data_s_i = 32'h0000_0055;
        tick();
        dm_store_i = 1'b0;
        chk("to1_we", 32'(ext_we_o), 32'd1);
        chk("to1_wdata", ext_data_o, 32'h0000_0055);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("to1_req%0d", i), 32'(ext_req_o), 32'd1);
            chk($sformatf("to1_nodone%0d", i), 32'(dm_store_done_o), 32'd0);
            tick();
        end
        chk("to1_req_off", 32'(ext_req_o), 32'd0);
        chk("to1_st_done", 32'(dm_store_done_o), 32'd1);
        chk("to1_err", 32'(err_o), 32'd1);
        chk("to1_err_addr", err_addr_o, 32'h8000_0004);

        // Second timeout keeps the first error address
        dm_store_i = 1'b1; dm_addr_i = 32'h8000_0008;
        tick();
        dm_store_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("to2_req%0d", i), 32'(ext_req_o), 32'd1);
            tick();
        end
        chk("to2_st_done", 32'(dm_store_done_o), 32'd1);
        chk("to2_err", 32'(err_o), 32'd1);
        chk("to2_err_addr", err_addr_o, 32'h8000_0004);
        chk("to2_ext_hold", ext_addr_o, 32'h8000_0008);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("clr_err", 32'(err_o), 32'd0);
        chk("clr_err_addr", err_addr_o, 32'h0);

        // Ack on the final timeout cycle wins
        dm_load_i = 1'b1; dm_addr_i = 32'h0020_0000;
        tick();
        dm_load_i = 1'b0;
        repeat (7) tick();
        chk("race_req8", 32'(ext_req_o), 32'd1);
        ext_ack_i = 1'b1; ext_data_i = 32'h1357_2468;
        tick();
        ext_ack_i = 1'b0; ext_data_i = 32'h0;
        chk("race_done", 32'(dm_load_done_o), 32'd1);
        chk("race_data", dm_data_l_o, 32'h1357_2468);
        chk("race_err", 32'(err_o), 32'd0);

        // Load and store together: store wins
        dm_load_i = 1'b1; dm_store_i = 1'b1; dm_addr_i = 32'h20;
        dm_data_s_i = 32'h9999_AAAA; dm_data_select_i = 4'b1111;
        tick();
        chk("both_st", 32'(dm_store_done_o), 32'd1);
        chk("both_no_ld", 32'(dm_load_done_o), 32'd0);
        dm_store_i = 1'b0;
        tick();
        chk("both_rd_data", dm_data_l_o, 32'h9999_AAAA);
        dm_load_i = 1'b0;
        tick();

        // Reset during EXT_BUSY
        dm_load_i = 1'b1; dm_addr_i = 32'h0030_0000;
        tick();
        dm_load_i = 1'b0;
        tick();
        chk("rmid_req_before", 32'(ext_req_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("rmid_req_drop", 32'(ext_req_o), 32'd0);
        chk("rmid_no_done", 32'(dm_load_done_o), 32'd0);
        tick();
        rst_i = 1'b0; ext_ack_i = 1'b1; ext_data_i = 32'h5555_5555;
        tick();
        ext_ack_i = 1'b0; ext_data_i = 32'h0;
        chk("rmid_ack_ign", 32'(dm_load_done_o), 32'd0);
        chk("rmid_req_low", 32'(ext_req_o), 32'd0);
        chk("rmid_ready", 32'(dm_ready_o), 32'd1);
        dm_load_i = 1'b1; dm_addr_i = 32'h10;
        tick();
        dm_load_i = 1'b0;
        chk("rmid_ram_done", 32'(dm_load_done_o), 32'd1);
        chk("rmid_ram_data", dm_data_l_o, 32'h1234_BB78);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/urv_dmem_responder.md
# urv_dmem_responder

Responder for the uRV CPU data-memory port. It accepts the core's load/store requests, serves a local byte-enabled RAM at one access per cycle, and forwards all other addresses to an external single-outstanding req/ack bus with a timeout. It sits between `urv_cpu` and the SoC interconnect and drives the core's `dm_ready_i`, `dm_load_done_i`, `dm_store_done_i` and `dm_data_l_i` inputs.

## Interface
- `g_ram_words`, 4096: local RAM depth in 32-bit words; power of two, 16..65536.
- `g_timeout_cycles`, 255: maximum cycles `ext_req_o` stays high without `ext_ack_i`; range 1..65535.
- `clk_i` in 1: single clock; all logic on the rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `dm_addr_i` in 32: byte address from the core.
- `dm_data_s_i` in 32: store data.
- `dm_data_select_i` in 4: byte enables; bit n selects byte lane n.
- `dm_store_i` in 1: store request.
- `dm_load_i` in 1: load request.
- `dm_ready_o` out 1: responder can accept a request this cycle.
- `dm_data_l_o` out 32: load data, valid while `dm_load_done_o` is high.
- `dm_load_done_o` out 1: one-cycle load completion pulse.
- `dm_store_done_o` out 1: one-cycle store completion pulse.
- `ext_addr_o` out 32: external byte address.
- `ext_data_o` out 32: external write data.
- `ext_sel_o` out 4: external byte enables.
- `ext_we_o` out 1: external write (1) or read (0).
- `ext_req_o` out 1: external request; held until ack or timeout.
- `ext_ack_i` in 1: external completion; sampled only while `ext_req_o` is high.
- `ext_data_i` in 32: external read data, valid with `ext_ack_i`.
- `err_o` out 1: sticky external-timeout flag.
- `err_addr_o` out 32: address of the first timed-out access since the last clear.
- `err_clr_i` in 1: clears `err_o` and `err_addr_o`.

## Operation
- **Accept.** A request is accepted in a cycle where `(dm_load_i | dm_store_i) & dm_ready_o`. If both strobes are high, the request is a store and no load completion is produced.
- **Decode.** `dm_addr_i < 4*g_ram_words` selects RAM. Any other address selects EXT. The RAM word index is `dm_addr_i[log2(g_ram_words)+1:2]`. Address bits [1:0] are ignored; byte enables define the lanes.
- **RAM store.** Enabled bytes are written at the accept edge. `dm_select == 0` writes nothing but still completes.
- **RAM load.** The addressed word is read synchronously and returned with the done pulse.
- **FSM states:** IDLE, EXT_BUSY, EXT_DONE.
  - IDLE: `dm_ready_o` = 1. A RAM access stays in IDLE. An EXT access latches addr/data/sel/we and goes to EXT_BUSY.
  - EXT_BUSY: `ext_req_o` = 1 and `dm_ready_o` = 0; the timeout counter increments every cycle.
    - `ext_ack_i` = 1: capture `ext_data_i` and go to EXT_DONE.
    - Counter reaches `g_timeout_cycles` without ack: data becomes 32'hDEAD_BEEF, set `err_o` (latching `err_addr_o` only if `err_o` was 0), go to EXT_DONE.
    - Ack and timeout in the same cycle: ack wins, no error.
  - EXT_DONE: `ext_req_o` = 0. Pulse the matching done signal and go to IDLE. `dm_ready_o` = 1, so a new request may be accepted in this cycle.
- **Error clear.** `err_clr_i` in the same cycle as a timeout: the set wins.
- **`ext_*` outputs** hold their latched values from the EXT_BUSY entry until the next EXT accept.

## Timing
- **Reset values:** `dm_ready_o` 1, done pulses 0, `dm_data_l_o` 0, `ext_req_o` 0, `ext_we_o` 0, `ext_addr_o`/`ext_data_o`/`ext_sel_o` 0, `err_o` 0, `err_addr_o` 0. State is IDLE and the counter is 0. RAM contents are not reset.
- **RAM access:** accept at cycle N, done pulse and load data at N+1. Back-to-back accepts every cycle are allowed, giving throughput 1/cycle.
- **EXT access:**
  - Accept at N; `ext_req_o` high from N+1.
  - Ack seen at cycle M gives a done pulse at M+1, with `ext_req_o` low at M+1.
  - Minimum latency is 2 cycles (ack at N+1 gives done at N+2).
  - Timeout: `ext_req_o` is high for exactly `g_timeout_cycles` cycles; done follows in the next cycle.
- **RAM after EXT:** a RAM accept in EXT_DONE produces its done pulse in the next cycle. Done pulses never overlap.
- **Reset mid-access:** asynchronous reset forces IDLE and deasserts `ext_req_o` immediately. No done pulse is issued for the aborted access. An `ext_ack_i` arriving after reset is ignored.
- **Ready dependence:** `dm_ready_o` is a function of FSM state only, with no combinational path from `dm_*` inputs.

## Test plan
- **RAM round trip.** Store 32'h1234_5678 to 0x10 with sel 4'b1111, then sel 4'b0010 with data 32'hAAAA_BBBB. Load 0x10 → 32'h1234_BB78 one cycle after accept; each store done pulse is 1 cycle wide.
- **RAM back-to-back.** Loads of 0x0, 0x4, 0x8 on three consecutive cycles → three consecutive done pulses with the correct words and `dm_ready_o` constantly 1.
- **EXT read with wait states.** Load of 0x0010_0000, ack after 3 req cycles with data 32'hCAFE_0001 → `ext_req_o` high 3 cycles, `ext_we_o` 0, `dm_load_done_o` with 32'hCAFE_0001 the following cycle, `dm_ready_o` low in between.
- **EXT timeout.** With `g_timeout_cycles` = 8, a store to 0x8000_0004 with no ack → req high 8 cycles, `dm_store_done_o` next cycle, `err_o` = 1 with `err_addr_o` 0x8000_0004. A second timeout at 0x8000_0008 leaves `err_addr_o` at 0x8000_0004. Then `err_clr_i` → `err_o` = 0.
- **Simultaneous events.** Ack on the final timeout cycle → real data returned, `err_o` stays 0. Load and store both high at accept → store performed, only `dm_store_done_o` pulses.
- **Reset mid-EXT.** Assert `rst_i` during EXT_BUSY → `ext_req_o` drops the same cycle with no done pulse. After reset release, a subsequent RAM load completes normally.
